spi_slave_multi: RTL
====================

# spi_slave_multi

Parametrised SPI slave with configurable word width, all four SPI modes, handshaked transmit/receive word interfaces and sticky error flags. It is the next generation of the team's fixed 8-bit, mode-0 SPI slave and sits between an external SPI master and on-chip logic in the `clk` domain. All SPI pins are oversampled by `clk`; `sck` is never used as a clock.

## Interface
- `WIDTH`, 8: bits per SPI word; must be 4 or more.
- `SYNC_STAGES`, 2: synchroniser flops on `ss`, `sck` and `mosi`; must be 2 or more.
- `FILL`, all ones (`{WIDTH{1'b1}}`): word shifted out when no transmit word is queued.

- `clk` input 1: the only clock. One clock; reset is asynchronous and active-high.
- `rst` input 1: asynchronous, active-high reset.
- `Vss`, `Vdd` inout 1: power pins, no logic connection.
- `ss` input 1: slave select, active low.
- `sck` input 1: SPI clock from the master.
- `mosi` input 1: master-out data.
- `miso` output 1: slave-out data.
- `miso_oe` output 1: high while selected.
- `mode` input 2: {CPOL, CPHA}, latched at selection start.
- `tx_data` input WIDTH: word to transmit.
- `tx_valid` input 1 and `tx_ready` output 1: transmit handshake.
- `rx_data` output WIDTH: last received word.
- `rx_valid` output 1 and `rx_ready` input 1: receive handshake.
- `busy` output 1: selected (synchronised `ss` low).
- `overrun` output 1: sticky flag for a received word that was dropped.
- `underrun` output 1: sticky flag for a FILL word that was sent.
- `clr_flags` input 1: clears both sticky flags.

## Operation
- **Synchronisers:** `ss`, `sck` and `mosi` each pass through `SYNC_STAGES` flops. A further flop holds the previous synchronised `sck` for edge detection. All three paths have equal delay.
- **Edge naming:** the leading edge is idle→active `sck` (rising if CPOL=0, falling if CPOL=1). The trailing edge is the opposite transition.
- **Selection start:** the cycle in which synchronised `ss` goes 1→0. In that cycle:
  - CPOL and CPHA are latched.
  - The bit counter is cleared.
  - The shift register loads the next TX word.
  - If CPHA=0, `miso` is set to the MSB of that word.
- **CPHA=0:**
  - Leading edge: `shift <= {shift[WIDTH-2:0], mosi}`, counter increments.
  - Trailing edge: `miso <= shift[WIDTH-1]`.
- **CPHA=1:**
  - Leading edge: `miso <= shift[WIDTH-1]`.
  - Trailing edge: shift and count as for CPHA=0.
- **Word end:** a sample with counter == WIDTH-1.
  - The received word is `{shift[WIDTH-2:0], mosi}`.
  - The counter wraps to 0.
  - The shift register loads the next TX word in the same cycle.
  - Words are continuous; there are no gap cycles.
- **Next TX word:** the holding register if it is full, which then empties. Otherwise `FILL`, and `underrun` is set.
- **TX holding register:** one entry. `tx_ready = !full`. Accepted on `tx_valid && tx_ready`. An accept and a consume in the same cycle leave the register empty; the consumed value is the old content.
- **RX register:**
  - At word end with `rx_valid` low: `rx_data` loads and `rx_valid` goes high.
  - `rx_valid` stays high until `rx_valid && rx_ready`, then clears next cycle.
  - At word end with `rx_valid` high and no handshake in that cycle: the new word is dropped, `rx_data` is unchanged and `overrun` is set.
  - A handshake in the same cycle as word end: the new word loads and `rx_valid` stays high.
- **Deselect mid-word** (synchronised `ss` goes high):
  - The partial word is discarded and the counter clears.
  - There is no `rx_valid` for the partial word.
  - The TX holding register is unaffected.
  - The loaded word is lost; this is not an underrun.
- **Ignored events:**
  - `sck` edges while deselected.
  - `mode` changes while selected.
- **Flag set/clear collision:** if `clr_flags` and a flag-set event occur in the same cycle, the set wins.

## Timing
- **Reset values:**
  - `miso` = 1, `miso_oe` = 0, `busy` = 0.
  - `rx_valid` = 0, `rx_data` = 0.
  - `tx_ready` = 1 (holding register empty).
  - `overrun` = 0, `underrun` = 0.
  - Counter = 0, latched mode = 0.
  - All synchroniser flops reset to 1, except `sck` flops, which reset to 0.
- **Reset mid-transfer:** asynchronous abort to the values above. A new transfer begins only at the next selection start.
- **Latency:** a pin edge is acted on at the (SYNC_STAGES+1)th `clk` rising edge after it is first sampled. `rx_valid` rises on that same edge for the last sample of a word.
- **Outputs:** `miso` and `miso_oe` are registered. `miso_oe` = `busy`.
- **Constraints on the master:**
  - `sck` high and low phases each last at least SYNC_STAGES+2 `clk` periods.
  - `ss` setup to the first `sck` edge is at least SYNC_STAGES+2 `clk` periods.

## Test plan
- **Mode 0 exchange:** WIDTH=8; queue 0xA5; master sends 0x3C in mode 0 → master receives 0xA5; `rx_data` = 0x3C with a single `rx_valid`; `tx_ready` is back to 1.
- **All four modes:** run each mode with `tx_data` 0x81 and `mosi` word 0x7E → correct bytes in both directions; `miso` changes only on the drive edge of the mode.
- **Underrun:** two back-to-back words with only one TX word queued → second word sent is 0xFF; `underrun` = 1; `clr_flags` clears it.
- **Overrun:** hold `rx_ready` = 0 over two words 0x11, 0x22 → `rx_data` stays 0x11; `overrun` = 1. Repeat with `rx_ready` asserted at the word-end cycle → `rx_data` = 0x22 and no overrun.
- **Abort:** deassert `ss` after 5 bits, then do a full transfer of 0x5A → no `rx_valid` for the partial word; next `rx_data` = 0x5A. Assert `rst` mid-word → all outputs return to reset values immediately, without waiting for `clk`.
- **Wide word:** WIDTH=16, SYNC_STAGES=3; send 0xBEEF with `sck` at the minimum phase length → `rx_data` = 0xBEEF; `rx_valid` asserts 4 `clk` edges after the last sampling edge is first sampled.

Source files
------------

// File: rtl/spi_slave_multi_if.sv
// Word-level transmit/receive handshake bundle shared by spi_slave_multi
// and the on-chip logic that feeds and drains it.
interface spi_slave_multi_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_multi.sv
// Oversampled SPI slave: all four modes, WIDTH-bit words, one-entry TX holding
// register, RX output register with overrun/underrun sticky flags.
module spi_slave_multi #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] FILL        = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire              Vss,
    inout  wire              Vdd,
    input  logic             ss,
    input  logic             sck,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [1:0]       mode,
    spi_slave_multi_if.slave bus,
    output logic             busy,
    output logic             overrun,
    output logic             underrun,
    input  logic             clr_flags
);
    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_prev;
    logic                   ss_s;
    logic                   sck_s;
    logic                   mosi_s;
    logic                   cpol;
    logic                   cpha;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       shift;
    logic [WIDTH-1:0]       hold;
    logic                   full;
    logic [WIDTH-1:0]       rx_data_q;
    logic                   rx_valid_q;
    logic [WIDTH-1:0]       next_word;
    logic [WIDTH-1:0]       rx_word;
    logic                   rise, fall, lead, trail;
    logic                   live, start, sample, drive, word_end, load;
    logic                   accept, handshake;
    logic                   unused_pwr;

    assign unused_pwr = Vss ^ Vdd;

    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign rise  = sck_s & ~sck_prev;
    assign fall  = ~sck_s & sck_prev;
    assign lead  = cpol ? fall : rise;
    assign trail = cpol ? rise : fall;

    // The IDLE->ACTIVE step doubles as the previous-ss flop for start detection.
    assign start    = (state == IDLE) && !ss_s;
    assign live     = (state == ACTIVE) && !ss_s;
    assign sample   = live && (cpha ? trail : lead);
    assign drive    = live && (cpha ? lead : trail);
    assign word_end = sample && (cnt == LAST);
    assign load     = start || word_end;

    assign next_word = full ? hold : FILL;
    assign rx_word   = {shift[WIDTH-2:0], mosi_s};
    assign accept    = bus.tx_valid && !full;
    assign handshake = rx_valid_q && bus.rx_ready;

    assign busy         = !ss_s;
    assign miso_oe      = !ss_s;
    assign bus.tx_ready = !full;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ss_sync    <= '1;
            sck_sync   <= '0;
            mosi_sync  <= '1;
            sck_prev   <= 1'b0;
            cpol       <= 1'b0;
            cpha       <= 1'b0;
            cnt        <= '0;
            shift      <= '0;
            hold       <= '0;
            full       <= 1'b0;
            miso       <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun    <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_prev  <= sck_s;
            state     <= ss_s ? IDLE : ACTIVE;

            if (start) begin
                cpol <= mode[1];
                cpha <= mode[0];
            end

            if (start || ss_s) begin
                cnt <= '0;
            end else if (sample) begin
                cnt <= word_end ? '0 : cnt + 1'b1;
            end

            if (load) begin
                shift <= next_word;
            end else if (sample) begin
                shift <= rx_word;
            end

            if (start && !mode[0]) begin
                miso <= next_word[WIDTH-1];
            end else if (drive) begin
                miso <= shift[WIDTH-1];
            end

            // A consume can only happen while full and an accept only while empty.
            if (load && full) begin
                full <= 1'b0;
            end else if (accept) begin
                full <= 1'b1;
                hold <= bus.tx_data;
            end

            if (load && !full) begin
                underrun <= 1'b1;
            end else if (clr_flags) begin
                underrun <= 1'b0;
            end

            if (word_end && (!rx_valid_q || bus.rx_ready)) begin
                rx_data_q  <= rx_word;
                rx_valid_q <= 1'b1;
            end else if (handshake) begin
                rx_valid_q <= 1'b0;
            end

            if (word_end && rx_valid_q && !bus.rx_ready) begin
                overrun <= 1'b1;
            end else if (clr_flags) begin
                overrun <= 1'b0;
            end
        end
    end
endmodule
